// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer, per-channel
// stability FSM with press/release strobes, and a sticky press interrupt.
module button_debounce #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_WIDTH       = 20
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [NUM_BTN-1:0] btn_raw_n,
    output logic [NUM_BTN-1:0] btn_db_n,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    input  logic               irq_clr,
    output logic               irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {REL, WAIT_P, PRS, WAIT_R} state_t;

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync;
    logic               irq_nxt;

    // Raw keys idle high, so the synchronizer resets to the released level
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= '1;
            sync  <= '1;
        end else begin
            sync1 <= btn_raw_n;
            sync  <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t               state;
        state_t               state_nxt;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] cnt_nxt;
        logic                 db;
        logic                 db_nxt;
        logic                 prs_p;
        logic                 prs_p_nxt;
        logic                 rel_p;
        logic                 rel_p_nxt;

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                state <= REL;
                cnt   <= '0;
                db    <= 1'b1;
                prs_p <= 1'b0;
                rel_p <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                db    <= db_nxt;
                prs_p <= prs_p_nxt;
                rel_p <= rel_p_nxt;
            end
        end

        // Any sample disagreeing with the pending level restarts the window
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            db_nxt    = db;
            prs_p_nxt = 1'b0;
            rel_p_nxt = 1'b0;
            case (state)
                REL: begin
                    if (!sync[i]) begin
                        state_nxt = WAIT_P;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_P: begin
                    if (sync[i]) begin
                        state_nxt = REL;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = PRS;
                        cnt_nxt   = '0;
                        db_nxt    = 1'b0;
                        prs_p_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_WIDTH'(1);
                    end
                end
                PRS: begin
                    if (sync[i]) begin
                        state_nxt = WAIT_R;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_R: begin
                    if (!sync[i]) begin
                        state_nxt = PRS;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = REL;
                        cnt_nxt   = '0;
                        db_nxt    = 1'b1;
                        rel_p_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign btn_db_n[i]      = db;
        assign press_pulse[i]   = prs_p;
        assign release_pulse[i] = rel_p;
    end

    // Set takes priority over clear so a press is never lost
    always_comb begin
        irq_nxt = irq;
        if (irq_clr) begin
            irq_nxt = 1'b0;
        end
        if (|press_pulse) begin
            irq_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a 4-cycle window and 4 channels.
module tb_button_debounce;

    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] raw;
    logic [NB-1:0] db;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic          irq_clr;
    logic          irq;

    int total = 0;
    int bad   = 0;

    button_debounce #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .btn_raw_n    (raw),
        .btn_db_n     (db),
        .press_pulse  (prs),
        .release_pulse(rel),
        .irq_clr      (irq_clr),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; outputs are settled when this returns
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        raw     = 4'b1111;
        irq_clr = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    logic [6:0] pat;

    initial begin
        do_reset();
        check("rst_db",  32'(db),  32'hf);
        check("rst_prs", 32'(prs), 32'h0);
        check("rst_rel", 32'(rel), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // Clean press on channel 0, then clean release
        raw = 4'b1110;
        step(6);
        check("cp_db_e5",  32'(db),  32'hf);
        check("cp_prs_e5", 32'(prs), 32'h0);
        step(1);
        check("cp_db_e6",  32'(db),  32'he);
        check("cp_prs_e6", 32'(prs), 32'h1);
        check("cp_irq_e6", 32'(irq), 32'h0);
        step(1);
        check("cp_prs_e7", 32'(prs), 32'h0);
        check("cp_irq_e7", 32'(irq), 32'h1);
        check("cp_db_e7",  32'(db),  32'he);
        raw = 4'b1111;
        step(6);
        check("cr_rel_e5", 32'(rel), 32'h0);
        step(1);
        check("cr_rel_e6", 32'(rel), 32'h1);
        check("cr_db_e6",  32'(db),  32'hf);
        check("cr_prs_e6", 32'(prs), 32'h0);
        step(1);
        check("cr_rel_e7", 32'(rel), 32'h0);
        check("cr_irq_e7", 32'(irq), 32'h1);

        // Glitch of 3 cycles never commits
        do_reset();
        raw = 4'b1110;
        step(3);
        raw = 4'b1111;
        for (int j = 0; j < 10; j++) begin
            step(1);
            check("gl_db",  32'(db),  32'hf);
            check("gl_prs", 32'(prs), 32'h0);
        end
        check("gl_irq", 32'(irq), 32'h0);

        // Bounce on channel 1 restarts the window
        do_reset();
        pat = 7'b0000100;  // bit j = sample j of 0,0,1,0,0,0,0
        for (int j = 0; j < 10; j++) begin
            raw = 4'b1111;
            raw[1] = (j < 7) ? pat[j] : 1'b0;
            step(1);
            if (j == 8) check("bn_prs_e8", 32'(prs), 32'h0);
            if (j == 9) check("bn_prs_e9", 32'(prs), 32'h2);
        end
        check("bn_db", 32'(db), 32'hd);

        // All channels at once
        do_reset();
        raw = 4'b0000;
        step(7);
        check("all_prs", 32'(prs), 32'hf);
        check("all_db",  32'(db),  32'h0);
        step(1);
        check("all_irq", 32'(irq), 32'h1);
        raw = 4'b1111;
        step(7);
        check("all_rel",    32'(rel), 32'hf);
        check("all_prs_r",  32'(prs), 32'h0);
        check("all_db_r",   32'(db),  32'hf);
        step(1);
        check("all_irq_r",  32'(irq), 32'h1);

        // irq_clr colliding with press_pulse: set wins, then clear alone
        do_reset();
        raw = 4'b1011;
        step(7);
        check("ic_prs", 32'(prs), 32'h4);
        irq_clr = 1'b1;
        step(1);
        check("ic_irq_set", 32'(irq), 32'h1);
        step(1);
        check("ic_irq_clr", 32'(irq), 32'h0);
        irq_clr = 1'b0;

        // Reset mid-window (WAIT_P, cnt=2) with key held
        do_reset();
        raw = 4'b1110;
        step(3);
        irq_clr = 1'b0;
        step(2);
        rst_n = 1'b0;
        #1;
        check("mr_db",  32'(db),  32'hf);
        check("mr_prs", 32'(prs), 32'h0);
        check("mr_irq", 32'(irq), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(6);
        check("mr_prs_e5", 32'(prs), 32'h0);
        step(1);
        check("mr_prs_e6", 32'(prs), 32'h1);
        check("mr_db_e6",  32'(db),  32'he);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable cycles required to accept a change (10 ms at 50 MHz); legal range 2 to 2^CNT_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 20: width of each per-channel counter.
REQ-004 SHALL have port clk_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port btn_raw_n, input, NUM_BTN bits: raw asynchronous board keys, active-low (0 = pressed).
REQ-007 SHALL have port btn_db_n, output, NUM_BTN bits: debounced level, active-low; drives button_external_connection_export downstream.
REQ-008 SHALL have port press_pulse, output, NUM_BTN bits: one-cycle strobe when a channel's debounced level commits to pressed.
REQ-009 SHALL have port release_pulse, output, NUM_BTN bits: one-cycle strobe when a channel's debounced level commits to released.
REQ-010 SHALL have port irq_clr, input, 1 bit: synchronous clear of irq.
REQ-011 SHALL have port irq, output, 1 bit: sticky flag, set by any press_pulse.

Function
REQ-012 SHALL pass each btn_raw_n bit through a two-flop synchronizer; the second flop output is sync[i].
REQ-013 SHALL run one independent FSM per channel with states REL (stable released), WAIT_P, PRS (stable pressed), and WAIT_R.
REQ-014 REL: if sync[i]==0, SHALL go to WAIT_P with cnt=0; otherwise SHALL stay in REL.
REQ-015 WAIT_P: if sync[i]==1 (bounce), SHALL return to REL with cnt=0.
REQ-016 WAIT_P: else if cnt==DEBOUNCE_CYCLES-1, SHALL go to PRS, set btn_db_n[i]=0, and assert press_pulse[i] for that one cycle.
REQ-017 WAIT_P: otherwise SHALL increment cnt.
REQ-018 PRS and WAIT_R SHALL mirror REQ-014 to REQ-017 with the polarity inverted; the commit from WAIT_R to REL SHALL set btn_db_n[i]=1 and assert release_pulse[i] for one cycle.
REQ-019 All outputs SHALL be registered.
REQ-020 Latency for a clean edge: btn_db_n[i] and the pulse SHALL change on rising edge DEBOUNCE_CYCLES+2, counting from the edge that first samples the new raw value (edge 0).
REQ-021 Any bounce within the window SHALL restart the full window; btn_db_n SHALL never toggle on a glitch shorter than DEBOUNCE_CYCLES cycles.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap; cnt SHALL be held at 0 in REL and PRS.
REQ-023 press_pulse[i] and release_pulse[i] SHALL never both be asserted in the same cycle; channels SHALL be fully independent, so simultaneous pulses on different channels are legal.
REQ-024 irq SHALL set on the cycle after any press_pulse bit is high and SHALL clear on the cycle after irq_clr is high.
REQ-025 If irq_clr is high in the same cycle as any press_pulse bit, set SHALL win and irq SHALL be 1.
REQ-026 release_pulse SHALL NOT affect irq.

Reset
REQ-027 While reset_reset_n==0, asynchronously: synchronizer flops SHALL be all 1, FSMs SHALL be in REL, cnt SHALL be 0, btn_db_n SHALL be all 1, press_pulse and release_pulse SHALL be 0, and irq SHALL be 0.
REQ-028 Reset asserted mid-window SHALL abandon the window; after release, a key still held low SHALL require a full new window before press_pulse asserts.
REQ-029 Deassertion of reset_reset_n SHALL be synchronized externally; the block SHALL resume on the first rising edge with reset high.

Verification (DEBOUNCE_CYCLES=4 unless noted)
REQ-030 Clean press: btn_raw_n 1111->1110 held -> btn_db_n=1110 and press_pulse=0001 for exactly one cycle at edge 6, irq=1 at edge 7.
REQ-031 Glitch: btn_raw_n[0] low for 3 cycles, then high -> btn_db_n stays 1111, no pulses, irq stays 0.
REQ-032 Bounce: raw[1] pattern 0,0,1,0,0,0,0 held low -> window restarts, press_pulse[1] occurs 4+2 edges after the final falling sample.
REQ-033 Simultaneous: raw 1111->0000 -> press_pulse=1111 in one cycle; then release all -> release_pulse=1111 in one cycle, irq unchanged.
REQ-034 irq_clr asserted in the same cycle as a press_pulse -> irq remains 1; irq_clr alone next cycle -> irq=0.
REQ-035 Reset in WAIT_P at cnt=2 -> outputs return to reset values immediately; key still held low after release -> press_pulse at edge 6 after release.
